// File: rtl/montexp_pkg.sv
// Shared types and default sizing for the montexp arbiter slice.
package montexp_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_R_WIDTH = 32;
    localparam int DEF_EWIDTH  = 8;
    localparam int DEF_S       = 8;

    typedef logic [DEF_WIDTH-1:0] limb_t;
    typedef limb_t [DEF_S-1:0]    operand_t;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request strictly after ptr (wrapping), as one-hot grant + index.
module rr_arbiter #(
    parameter  int NREQ = 3,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] pick;

    // Prefer requests above the pointer; fall back to the lowest request overall (wrap).
    always_comb begin
        masked = '0;
        for (int i = 0; i < NREQ; i++) masked[i] = req[i] && (IW'(i) > ptr);
        pick  = (|masked) ? masked : req;
        grant = '0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/montexp_arbiter.sv
// Round-robin front end sharing one montexp engine among NREQ requesters.
// Optional busy timeout enabled by defining MONTEXP_ARB_TIMEOUT_EN.
module montexp_arbiter
    import montexp_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int R_WIDTH = DEF_R_WIDTH,
    parameter  int EWIDTH  = DEF_EWIDTH,
    parameter  int S       = DEF_S,
    parameter  int NREQ    = 3,
    parameter  int TIMEOUT = 4096,
    localparam int OW      = $clog2(NREQ)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ-1:0][S-1:0][WIDTH-1:0]   req_base,
    input  logic [NREQ-1:0][EWIDTH-1:0]         req_exponent,
    input  logic [NREQ-1:0][S-1:0][WIDTH-1:0]   req_n,
    input  logic [NREQ-1:0][R_WIDTH-1:0]        req_n_prime,
    input  logic [NREQ-1:0][S-1:0][WIDTH-1:0]   req_mont_one,
    output logic [NREQ-1:0]                     rsp_valid,
    input  logic [NREQ-1:0]                     rsp_ready,
    output logic [S-1:0][WIDTH-1:0]             rsp_result,
    output logic                                rsp_err,
    output logic                                busy,
    output logic [OW-1:0]                       owner,
    output logic                                me_start,
    output logic [S-1:0][WIDTH-1:0]             me_base,
    output logic [EWIDTH-1:0]                   me_exponent,
    output logic [S-1:0][WIDTH-1:0]             me_n,
    output logic [R_WIDTH-1:0]                  me_n_prime,
    output logic [S-1:0][WIDTH-1:0]             me_mont_one,
    input  logic [S-1:0][WIDTH-1:0]             me_result,
    input  logic                                me_done
);

    arb_state_t                 state_q, state_d;
    logic [OW-1:0]              ptr_q, ptr_d, owner_q, owner_d;
    logic [S-1:0][WIDTH-1:0]    base_q, base_d, n_q, n_d, mo_q, mo_d, result_q, result_d;
    logic [EWIDTH-1:0]          exp_q, exp_d;
    logic [R_WIDTH-1:0]         np_q, np_d;
    logic [NREQ-1:0]            grant;
    logic [OW-1:0]              gidx;

`ifdef MONTEXP_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        base_d    = base_q;
        exp_d     = exp_q;
        n_d       = n_q;
        np_d      = np_q;
        mo_d      = mo_q;
        result_d  = result_q;
        req_ready = '0;
        rsp_valid = '0;
        me_start  = 1'b0;
`ifdef MONTEXP_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                // Gated by reset so a held request never sees a grant while in reset.
                req_ready = rst ? grant : '0;
                if (|(req_valid & req_ready)) begin
                    owner_d = gidx;
                    base_d  = req_base[gidx];
                    exp_d   = req_exponent[gidx];
                    n_d     = req_n[gidx];
                    np_d    = req_n_prime[gidx];
                    mo_d    = req_mont_one[gidx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                me_start = 1'b1;
                state_d  = BUSY;
`ifdef MONTEXP_ARB_TIMEOUT_EN
                cnt_d    = '0;
                err_d    = 1'b0;
`endif
            end
            BUSY: begin
                if (me_done) begin
                    result_d = me_result;
                    state_d  = RESP;
                end
`ifdef MONTEXP_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= OW'(NREQ - 1);
            owner_q  <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            np_q     <= '0;
            mo_q     <= '0;
            result_q <= '0;
`ifdef MONTEXP_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            n_q      <= n_d;
            np_q     <= np_d;
            mo_q     <= mo_d;
            result_q <= result_d;
`ifdef MONTEXP_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

`ifdef MONTEXP_ARB_TIMEOUT_EN
    assign rsp_err = err_q && (state_q == RESP);
`else
    assign rsp_err = 1'b0;
`endif

    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;
    assign rsp_result  = result_q;
    assign me_base     = base_q;
    assign me_exponent = exp_q;
    assign me_n        = n_q;
    assign me_n_prime  = np_q;
    assign me_mont_one = mo_q;

endmodule

// File: tb/tb_montexp_arbiter.sv
// Scoreboard bench for montexp_arbiter with a stub engine (done 5 cycles after start,
// result = base XOR exponent across the operand).
module tb_montexp_arbiter;
    localparam int WIDTH = 32, R_WIDTH = 32, EWIDTH = 8, S = 8, NREQ = 3, TO = 16;
    localparam int IW = $clog2(NREQ);
    typedef logic [S-1:0][WIDTH-1:0] opnd_t;
    typedef struct {
        int                 owner;
        opnd_t              base;
        logic [EWIDTH-1:0]  e;
        opnd_t              n;
        logic [R_WIDTH-1:0] np;
        opnd_t              mo;
        opnd_t              res;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ-1:0][S-1:0][WIDTH-1:0] req_base, req_n, req_mont_one;
    logic [NREQ-1:0][EWIDTH-1:0] req_exponent;
    logic [NREQ-1:0][R_WIDTH-1:0] req_n_prime;
    opnd_t rsp_result, me_base, me_n, me_mont_one, me_result;
    logic rsp_err, busy, me_start, me_done;
    logic [IW-1:0] owner;
    logic [EWIDTH-1:0] me_exponent;
    logic [R_WIDTH-1:0] me_n_prime;

    montexp_arbiter #(.WIDTH(WIDTH), .R_WIDTH(R_WIDTH), .EWIDTH(EWIDTH), .S(S),
                      .NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_exponent(req_exponent), .req_n(req_n),
        .req_n_prime(req_n_prime), .req_mont_one(req_mont_one),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy), .owner(owner), .me_start(me_start),
        .me_base(me_base), .me_exponent(me_exponent), .me_n(me_n),
        .me_n_prime(me_n_prime), .me_mont_one(me_mont_one),
        .me_result(me_result), .me_done(me_done));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(string nm, logic [S*WIDTH-1:0] act, logic [S*WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Stub engine
    logic hang = 1'b0;
    int   sc;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc <= 0; me_done <= 1'b0; me_result <= '0;
        end else begin
            me_done <= (sc == 1) && !hang;
            if (me_start) begin
                sc <= 4;
                me_result <= me_base ^ opnd_t'(me_exponent);
            end else if (sc > 0) sc <= sc - 1;
        end
    end

    // Reference model + monitor
    typedef enum {M_IDLE, M_ISSUE, M_WAIT, M_RESP} mst_t;
    mst_t mst = M_IDLE;
    int   last = NREQ - 1, mown = 0, wcnt = 0, w;
    bit   merr = 1'b0;
    exp_t exp_q[$];
    exp_t em;
    logic [NREQ-1:0] eg, er;

    function automatic int win(logic [NREQ-1:0] v, int l);
        for (int k = 1; k <= NREQ; k++) if (v[(l + k) % NREQ]) return (l + k) % NREQ;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_me_start", me_start, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_owner", owner, 0);
            chk("rst_me_base", me_base, 0);
            chk("rst_rsp_result", rsp_result, 0);
            mst = M_IDLE; last = NREQ - 1; exp_q.delete();
        end else begin
            w  = win(req_valid, last);
            eg = '0;
            if (mst == M_IDLE && w >= 0) eg[w] = 1'b1;
            er = '0;
            if (mst == M_RESP) er[mown] = 1'b1;
            chk("req_ready", req_ready, eg);
            chk("busy", busy, mst != M_IDLE);
            chk("me_start", me_start, mst == M_ISSUE);
            chk("rsp_valid", rsp_valid, er);
            if (mst == M_ISSUE || mst == M_RESP) begin
                chk("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    em = exp_q[0];
                    chk("owner", owner, em.owner);
                    chk("me_base", me_base, em.base);
                    chk("me_exponent", me_exponent, em.e);
                    chk("me_n", me_n, em.n);
                    chk("me_n_prime", me_n_prime, em.np);
                    chk("me_mont_one", me_mont_one, em.mo);
                    if (mst == M_RESP) begin
                        chk("rsp_result", rsp_result, merr ? '0 : em.res);
                        chk("rsp_err", rsp_err, merr);
                    end
                end
            end
            case (mst)
                M_IDLE:  if (|(req_valid & req_ready)) begin mown = w; mst = M_ISSUE; end
                M_ISSUE: begin mst = M_WAIT; wcnt = 0; end
                M_WAIT: begin
                    wcnt++;
                    if (me_done) begin mst = M_RESP; merr = 1'b0; end
`ifdef MONTEXP_ARB_TIMEOUT_EN
                    else if (wcnt == TO) begin mst = M_RESP; merr = 1'b1; end
`endif
                end
                M_RESP: if (rsp_ready[mown]) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    last = mown; mst = M_IDLE;
                end
                default: mst = M_IDLE;
            endcase
        end
    end

    // Driver
    int p_req[NREQ];
    int p_rdy = 100;
    int order_q[$];

    task automatic new_req(int i);
        for (int k = 0; k < S; k++) begin
            req_base[i][k] = $urandom; req_n[i][k] = $urandom; req_mont_one[i][k] = $urandom;
        end
        req_exponent[i] = EWIDTH'($urandom);
        req_n_prime[i]  = $urandom;
        req_valid[i]    = 1'b1;
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        exp_t e;
        @(negedge clk);
        acc = req_valid & req_ready & {NREQ{rst}};
        for (int i = 0; i < NREQ; i++) if (acc[i]) begin
            e.owner = i; e.base = req_base[i]; e.e = req_exponent[i]; e.n = req_n[i];
            e.np = req_n_prime[i]; e.mo = req_mont_one[i];
            e.res = req_base[i] ^ opnd_t'(req_exponent[i]);
            exp_q.push_back(e);
            order_q.push_back(i);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(99) < p_req[i]) new_req(i);
            rsp_ready[i] = ($urandom_range(99) < p_rdy);
        end
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        for (int i = 0; i < NREQ; i++) p_req[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        req_valid = '0; rsp_ready = '0; req_base = '0; req_n = '0; req_mont_one = '0;
        req_exponent = '0; req_n_prime = '0;
        for (int i = 0; i < NREQ; i++) p_req[i] = 0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: single request with fixed operands, response held until read
        p_rdy = 0;
        req_base[0] = '0; req_base[0][0] = 32'd262148;
        req_n[0] = '0; req_n[0][0] = 32'd65793;
        req_mont_one[0] = '0; req_mont_one[0][0] = 32'd65537;
        req_n_prime[0] = 32'd4278190335; req_exponent[0] = 8'd3; req_valid[0] = 1'b1;
        for (int c = 0; c < 30 && !rsp_valid[0]; c++) step();
        chk("t1_rsp_valid", rsp_valid, 3'b001);
        chk("t1_limb0", rsp_result[0], 32'd262151);
        chk("t1_upper_limbs", rsp_result[S-1:1], 0);
        p_rdy = 100; run(4);

        // 2: all three at once after reset -> 0,1,2
        do_reset(); order_q.delete();
        new_req(0); new_req(1); new_req(2);
        run(30);
        chk("t2_count", order_q.size(), 3);
        chk("t2_g0", order_q[0], 0);
        chk("t2_g1", order_q[1], 1);
        chk("t2_g2", order_q[2], 2);

        // 3: owner withholds rsp_ready; pending request must not be granted
        p_rdy = 0; new_req(0);
        for (int c = 0; c < 30 && !rsp_valid[0]; c++) step();
        new_req(1);
        run(10);
        chk("t3_held_valid", rsp_valid, 3'b001);
        chk("t3_no_grant", req_ready, 0);
        p_rdy = 100; run(20);

        // 4: reset while BUSY, then 0 wins over 2
        new_req(0); run(4);
        new_req(1);
        #1 rst = 1'b0;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_req_ready", req_ready, 0);
        chk("t4_rsp_valid", rsp_valid, 0);
        chk("t4_me_start", me_start, 0);
        chk("t4_owner", owner, 0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        order_q.delete();
        new_req(0); new_req(2);
        run(20);
        chk("t4_count", order_q.size(), 2);
        chk("t4_first", order_q[0], 0);
        chk("t4_second", order_q[1], 2);

        // 5: requesters 1 and 2 re-request continuously -> 1,2,1,2
        order_q.delete();
        p_req[1] = 100; p_req[2] = 100;
        run(34);
        p_req[1] = 0; p_req[2] = 0;
        run(12);
        chk("t5_count", order_q.size() >= 4, 1);
        chk("t5_g0", order_q[0], 1);
        chk("t5_g1", order_q[1], 2);
        chk("t5_g2", order_q[2], 1);
        chk("t5_g3", order_q[3], 2);

        // 6: engine never finishes
        hang = 1'b1; p_rdy = 0; new_req(0);
`ifdef MONTEXP_ARB_TIMEOUT_EN
        for (int c = 0; c < 40 && !rsp_valid[0]; c++) step();
        chk("t6_rsp_valid", rsp_valid, 3'b001);
        chk("t6_rsp_err", rsp_err, 1);
        p_rdy = 100; run(4);
`else
        run(1000);
        chk("t6_busy_held", busy, 1);
        chk("t6_no_rsp", rsp_valid, 0);
`endif
        hang = 1'b0;
        do_reset();

        // Random traffic
        for (int blk = 0; blk < 15; blk++) begin
            for (int i = 0; i < NREQ; i++) p_req[i] = $urandom_range(100);
            p_rdy = $urandom_range(100, 10);
            run(100);
        end
        for (int i = 0; i < NREQ; i++) p_req[i] = 0;
        p_rdy = 100;
        run(30);
        chk("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
